cwt_sequencer_param: RTL

- Parametrised next-generation CWT controller: one FFT frame, then NUM_SCALES passes of multiply, IFFT and store.
- Per scale it streams FFT bins against the wavelet ROM, loads the IFFT input register file, starts the IFFT, and writes the result into that scale's output RAM bank.
- Sits between the FFT core, the 128x1 operand mux/multiplier, the wavelet ROMs, the IFFT core and the scale RAM banks.

---
 rtl/cwt_pkg.sv | 31 +++
 rtl/cwt_onehot_delay.sv | 56 +++++
 rtl/cwt_sequencer_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cwt_pkg.sv
// Shared state encoding, width helpers and default sizes for the CWT sequencer.
package cwt_pkg;

    localparam int unsigned DEF_N_POINTS    = 128;
    localparam int unsigned DEF_NUM_SCALES  = 15;
    localparam int unsigned DEF_LANES       = 32;
    localparam int unsigned DEF_MUL_LAT     = 1;
    localparam int unsigned DEF_TIMEOUT_CYC = 1023;

    typedef enum logic [2:0] {
        IDLE,
        FFT_WAIT,
        FFT_CAP,
        MUL,
        IFFT_GO,
        IFFT_WAIT,
        STORE,
        DONE
    } cwt_state_e;

    // Address width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Scale counter width: holds 0..num_scales.
    function automatic int unsigned scale_w(input int unsigned num_scales);
        return $clog2(num_scales) + 1;
    endfunction

endpackage

// File: rtl/cwt_onehot_delay.sv
// Delays the bin index issued to the multiplier by MUL_LAT cycles and decodes it
// into the one-hot IFFT register-file enable. sel/vld are the values sel_mux takes next.
module cwt_onehot_delay
    import cwt_pkg::*;
#(
    parameter int unsigned N_POINTS = DEF_N_POINTS,
    parameter int unsigned MUL_LAT  = DEF_MUL_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(N_POINTS)-1:0] sel,
    input  logic                        vld,
    output logic [N_POINTS-1:0]         reg_en_ifft
);

    localparam int unsigned SW = $clog2(N_POINTS);
    localparam logic [N_POINTS-1:0] ONE = N_POINTS'(1);

    logic [SW-1:0] tap_sel;
    logic          tap_vld;

    if (MUL_LAT == 0) begin : g_direct
        assign tap_sel = sel;
        assign tap_vld = vld;
    end else begin : g_line
        logic [MUL_LAT-1:0][SW-1:0] sel_q;
        logic [MUL_LAT-1:0]         vld_q;

        // Index line is kept narrow; decoding happens only at the output register.
        always_ff @(posedge clk) begin
            if (!rst) begin
                sel_q <= '0;
                vld_q <= '0;
            end else begin
                sel_q[0] <= sel;
                vld_q[0] <= vld;
                for (int i = 1; i < MUL_LAT; i++) begin
                    sel_q[i] <= sel_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign tap_sel = sel_q[MUL_LAT-1];
        assign tap_vld = vld_q[MUL_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_en_ifft <= '0;
        end else begin
            reg_en_ifft <= tap_vld ? (ONE << tap_sel) : '0;
        end
    end

endmodule

// File: rtl/cwt_sequencer_param.sv
// CWT frame sequencer: FFT capture, then per scale multiply / IFFT / bank store.
// Optional watchdog on the FFT and IFFT waits enabled by `define CWT_SEQ_TIMEOUT_EN.
module cwt_sequencer_param
    import cwt_pkg::*;
#(
    parameter int unsigned N_POINTS    = DEF_N_POINTS,
    parameter int unsigned NUM_SCALES  = DEF_NUM_SCALES,
    parameter int unsigned LANES       = DEF_LANES,
    parameter int unsigned MUL_LAT     = DEF_MUL_LAT,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       fft_ready_inputs,
    input  logic                                       fft_correct,
    input  logic                                       ifft_correct,
    output logic [N_POINTS-1:0]                        reg_en_fft,
    output logic [$clog2(N_POINTS)-1:0]                sel_mux,
    output logic [$clog2(N_POINTS*NUM_SCALES)-1:0]     wavelet_rom_addr,
    output logic [N_POINTS-1:0]                        reg_en_ifft,
    output logic [clog2_min1(N_POINTS/LANES)-1:0]      ifft_sel_mux,
    output logic                                       ifft_ready_inputs,
    output logic [NUM_SCALES-1:0]                      scale_ram_we,
    output logic [clog2_min1(N_POINTS/LANES)-1:0]      scale_ram_addr,
    output logic [scale_w(NUM_SCALES)-1:0]             scale_idx,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       err
);

    localparam int unsigned SW      = $clog2(N_POINTS);
    localparam int unsigned AW      = $clog2(N_POINTS * NUM_SCALES);
    localparam int unsigned G       = N_POINTS / LANES;
    localparam int unsigned GW      = clog2_min1(G);
    localparam int unsigned SCW     = scale_w(NUM_SCALES);
    localparam int unsigned MUL_CYC = N_POINTS + MUL_LAT;
    localparam int unsigned CW      = $clog2(MUL_CYC + 1);

    localparam logic [N_POINTS-1:0]   ALL_ONES  = '1;
    localparam logic [N_POINTS-1:0]   LANE_MASK = ALL_ONES >> (N_POINTS - LANES);
    localparam logic [NUM_SCALES-1:0] WE_ONE    = NUM_SCALES'(1);
    localparam logic [SCW-1:0]        LAST_SCL  = SCW'(NUM_SCALES - 1);

    if (((N_POINTS & (N_POINTS - 1)) != 0) || (N_POINTS < LANES) || (NUM_SCALES < 1) ||
        (NUM_SCALES > 32) || (MUL_LAT > 4) || (TIMEOUT_CYC < 1)) begin : g_bad_params
        $error("cwt_sequencer_param: illegal parameter set");
    end

    cwt_state_e     state;
    logic [CW-1:0]  cnt;
    logic [SCW-1:0] scale;
    logic           grp_last;
    logic           abort_c;

    logic           mul_vld_n;
    logic [SW-1:0]  mul_idx_n;
    logic [SCW-1:0] mul_scale_n;

    assign grp_last  = (cnt == CW'(G - 1));
    assign scale_idx = scale;

    // Bin/scale that the multiplier operands take on the coming cycle.
    always_comb begin
        mul_vld_n   = 1'b0;
        mul_idx_n   = '0;
        mul_scale_n = scale;
        if (state == FFT_CAP && grp_last) begin
            mul_vld_n   = 1'b1;
            mul_scale_n = '0;
        end else if (state == STORE && grp_last && scale != LAST_SCL) begin
            mul_vld_n   = 1'b1;
            mul_scale_n = SCW'(scale + 1'b1);
        end else if (state == MUL && cnt < CW'(N_POINTS - 1)) begin
            mul_vld_n = 1'b1;
            mul_idx_n = SW'(cnt + 1'b1);
        end
    end

    cwt_onehot_delay #(
        .N_POINTS (N_POINTS),
        .MUL_LAT  (MUL_LAT)
    ) u_onehot_delay (
        .clk         (clk),
        .rst         (rst),
        .sel         (mul_idx_n),
        .vld         (mul_vld_n),
        .reg_en_ifft (reg_en_ifft)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            scale             <= '0;
            reg_en_fft        <= '0;
            sel_mux           <= '0;
            wavelet_rom_addr  <= '0;
            ifft_sel_mux      <= '0;
            ifft_ready_inputs <= 1'b0;
            scale_ram_we      <= '0;
            scale_ram_addr    <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            reg_en_fft        <= '0;
            ifft_sel_mux      <= '0;
            ifft_ready_inputs <= 1'b0;
            scale_ram_we      <= '0;
            scale_ram_addr    <= '0;
            done              <= 1'b0;
            sel_mux           <= mul_idx_n;
            wavelet_rom_addr  <= mul_vld_n ? AW'({mul_scale_n, mul_idx_n}) : '0;

            case (state)
                IDLE: begin
                    if (fft_ready_inputs) begin
                        state <= FFT_WAIT;
                        busy  <= 1'b1;
                    end
                end
                FFT_WAIT: begin
                    if (fft_correct) begin
                        state      <= FFT_CAP;
                        cnt        <= '0;
                        reg_en_fft <= LANE_MASK;
                    end else if (abort_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FFT_CAP: begin
                    if (grp_last) begin
                        state <= MUL;
                        cnt   <= '0;
                        scale <= '0;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        reg_en_fft <= LANE_MASK << (LANES * (32'(cnt) + 1));
                    end
                end
                MUL: begin
                    if (cnt == CW'(MUL_CYC - 1)) begin
                        state             <= IFFT_GO;
                        ifft_ready_inputs <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IFFT_GO: begin
                    state <= IFFT_WAIT;
                end
                IFFT_WAIT: begin
                    if (ifft_correct) begin
                        state        <= STORE;
                        cnt          <= '0;
                        scale_ram_we <= WE_ONE << scale;
                    end else if (abort_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        scale <= '0;
                    end
                end
                STORE: begin
                    if (grp_last) begin
                        if (scale == LAST_SCL) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= MUL;
                            cnt   <= '0;
                            scale <= SCW'(scale + 1'b1);
                        end
                    end else begin
                        cnt            <= cnt + 1'b1;
                        ifft_sel_mux   <= GW'(cnt + 1'b1);
                        scale_ram_addr <= GW'(cnt + 1'b1);
                        scale_ram_we   <= WE_ONE << scale;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    scale <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CWT_SEQ_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

    logic [WDW-1:0] wd;
    logic           in_wait;
    logic           pulse_c;

    assign in_wait = (state == FFT_WAIT) || (state == IFFT_WAIT);
    assign pulse_c = (state == FFT_WAIT) ? fft_correct : ifft_correct;
    assign abort_c = in_wait && !pulse_c && (wd == WDW'(TIMEOUT_CYC - 1));

    // Wait-cycle counter is zero outside the waits, so each wait starts from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd <= in_wait ? WDW'(wd + 1'b1) : '0;
            if (abort_c) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign abort_c = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
